// File: rtl/bin2bcd_module.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// The displayed value and the overflow flag update only when a conversion
// completes, so the downstream display never shows a partial result.
module bin2bcd_module #(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_sig,
  input  logic [BIN_W-1:0]      bin_data,
  output logic                  busy_sig,
  output logic                  done_sig,
  output logic [4*DIGITS-1:0]   number_sig,
  output logic                  ovf_sig
);

  localparam int unsigned BcdW   = 4 * DIGITS;
  localparam int unsigned SrW    = BcdW + BIN_W;
  localparam int unsigned CntW   = $clog2(BIN_W + 1);
  localparam int unsigned MaxVal = 10 ** DIGITS - 1;
  localparam logic [CntW-1:0] LastStep = CntW'(BIN_W - 1);
  localparam logic [BcdW-1:0] SatVal   = {DIGITS{4'h9}};

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e          state_q;
  // {BCD accumulator, operand} held as one shift register
  logic [SrW-1:0]  sr_q;
  logic [SrW-1:0]  sr_adj;
  logic [SrW-1:0]  sr_d;
  logic [CntW-1:0] cnt_q;
  logic            ovf_pend_q;
  logic            ovf_d;
  logic            busy_q;
  logic            done_q;
  logic [BcdW-1:0] number_q;
  logic            ovf_q;

  // Add-3 correction on every accumulator digit, then shift the whole register left by one
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    sr_d  = sr_adj << 1;
    ovf_d = (32'(bin_data) > MaxVal);
  end

  // Control FSM with registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      number_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_sig) begin
            sr_q       <= {{BcdW{1'b0}}, bin_data};
            cnt_q      <= '0;
            ovf_pend_q <= ovf_d;
            busy_q     <= 1'b1;
            state_q    <= StConv;
          end
        end
        StConv: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            // Out-of-range operands saturate; the accumulator is not meaningful for them
            if (ovf_pend_q) begin
              number_q <= SatVal;
              ovf_q    <= 1'b1;
            end else begin
              number_q <= sr_d[SrW-1 -: BcdW];
              ovf_q    <= 1'b0;
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_sig   = busy_q;
  assign done_sig   = done_q;
  assign number_sig = number_q;
  assign ovf_sig    = ovf_q;

endmodule
